// File: rtl/aes_key_expander_pkg.sv
// Shared types and key-length helpers for the AES key-schedule engine.
package aes_key_expander_pkg;

  typedef logic [0:31] word_t;  // MSB-first column word, byte 0 = bits [0:7]
  typedef logic [7:0]  byte_t;

  typedef enum logic {ST_IDLE, ST_EXPAND} state_e;

  function automatic int nk(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr(input int key_bits);
    return nk(key_bits) + 6;
  endfunction

  function automatic int tw(input int key_bits);
    return 4 * (nr(key_bits) + 1);
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Request / status / round-key read bundle between a cipher core and the key expander.
interface aes_key_expander_if #(parameter int KEY_BITS = 128);
  logic                  start;
  logic [0:KEY_BITS-1]   key_in;
  logic                  busy;
  logic                  done;
  logic                  key_valid;
  logic [3:0]            rd_round;
  logic [0:127]          rd_key;

  modport master (output start, key_in, rd_round,
                  input  busy, done, key_valid, rd_key);
  modport slave  (input  start, key_in, rd_round,
                  output busy, done, key_valid, rd_key);
endinterface

// File: rtl/aes_key_expander_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) (as x^254) followed by the affine map.
module aes_key_expander_sbox
  import aes_key_expander_pkg::*;
(
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output byte_t      sub_o
);

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p  = 8'h00;
    byte_t aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Square-and-multiply; 0 maps to 0 as the S-box requires.
  function automatic byte_t gf_inv(input byte_t x);
    byte_t r    = 8'h01;
    byte_t base = x;
    byte_t e    = 8'd254;
    for (int k = 0; k < 8; k++) begin
      if (e[k]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  byte_t inv;

  always_comb begin
    inv   = gf_inv({row_i, col_i});
    sub_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule: one word per clock into a round-key store
// with a registered, round-indexed read port.
module aes_key_expander
  import aes_key_expander_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic               clk,
  input  logic               rst,
  aes_key_expander_if.slave  bus
);

  localparam int NK = nk(KEY_BITS);
  localparam int NR = nr(KEY_BITS);
  localparam int TW = tw(KEY_BITS);
  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [5:0] TW_LAST = 6'(TW - 1);
  localparam logic [3:0] NR_R    = 4'(NR);
  localparam logic [2:0] NK_LAST = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  state_e       state_q, state_d;
  word_t        w_q [TW];
  logic [5:0]   cnt_q;      // index i of the next word to produce
  logic [2:0]   mod_q;      // i % NK, kept incrementally
  byte_t        rcon_q;
  logic         done_q, valid_q;
  logic [0:127] rd_key_q;

  logic         busy, accept, last_word;
  word_t        prev_w, back_w, sub_in, sub_out, t_w;
  logic [5:0]   rd_idx;
  byte_t        sub_b [4];

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_EXPAND;
      ST_EXPAND: if (last_word) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb busy = (state_q == ST_EXPAND);

  assign accept    = bus.start & ~busy;
  assign last_word = (cnt_q == TW_LAST);

  // Word datapath: w[i] = w[i-NK] ^ T(w[i-1])
  assign prev_w = w_q[cnt_q - 6'd1];
  assign back_w = w_q[cnt_q - NK_W];
  assign sub_in = (mod_q == 3'd0) ? {prev_w[8:31], prev_w[0:7]} : prev_w;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_key_expander_sbox u_sbox (
      .row_i (sub_in[8*g +: 4]),
      .col_i (sub_in[8*g+4 +: 4]),
      .sub_o (sub_b[g])
    );
  end
  assign sub_out = {sub_b[0], sub_b[1], sub_b[2], sub_b[3]};

  always_comb begin
    t_w = prev_w;
    if (mod_q == 3'd0)                 t_w = sub_out ^ {rcon_q, 24'h000000};
    else if (NK == 8 && mod_q == 3'd4) t_w = sub_out;
  end

  // NOTE: the schedule store has no reset; key_valid gates its use, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int k = 0; k < NK; k++) w_q[k] <= bus.key_in[32*k +: 32];
      end else if (busy) begin
        w_q[cnt_q] <= back_w ^ t_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mod_q   <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        cnt_q   <= NK_W;
        mod_q   <= '0;
        rcon_q  <= 8'h01;
        valid_q <= 1'b0;
      end else if (busy) begin
        cnt_q <= cnt_q + 6'd1;
        mod_q <= (mod_q == NK_LAST) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
        if (last_word) begin
          valid_q <= 1'b1;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign rd_idx = {bus.rd_round, 2'b00};

  always_ff @(posedge clk) begin
    if (rst)                     rd_key_q <= '0;
    else if (bus.rd_round > NR_R) rd_key_q <= '0;
    else rd_key_q <= {w_q[rd_idx], w_q[rd_idx + 6'd1], w_q[rd_idx + 6'd2], w_q[rd_idx + 6'd3]};
  end

  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.key_valid = valid_q;
  assign bus.rd_key    = rd_key_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Drives AES-128/192/256 expanders side by side against a FIPS-197 style schedule model.
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start_v [3];
  logic [0:255] key_v   [3];
  logic [3:0]   rd_v    [3];

  aes_key_expander_if #(.KEY_BITS(128)) if128 ();
  aes_key_expander_if #(.KEY_BITS(192)) if192 ();
  aes_key_expander_if #(.KEY_BITS(256)) if256 ();

  assign if128.start = start_v[0];  assign if128.key_in = key_v[0][0:127]; assign if128.rd_round = rd_v[0];
  assign if192.start = start_v[1];  assign if192.key_in = key_v[1][0:191]; assign if192.rd_round = rd_v[1];
  assign if256.start = start_v[2];  assign if256.key_in = key_v[2];        assign if256.rd_round = rd_v[2];

  aes_key_expander #(.KEY_BITS(128)) u_dut128 (.clk(clk), .rst(rst), .bus(if128));
  aes_key_expander #(.KEY_BITS(192)) u_dut192 (.clk(clk), .rst(rst), .bus(if192));
  aes_key_expander #(.KEY_BITS(256)) u_dut256 (.clk(clk), .rst(rst), .bus(if256));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  function automatic int nk_of(input int s); return 4 + 2 * s; endfunction
  function automatic int nr_of(input int s); return nk_of(s) + 6; endfunction

  function automatic logic [2:0] flags(input int s);
    case (s)
      0:       return {if128.busy, if128.done, if128.key_valid};
      1:       return {if192.busy, if192.done, if192.key_valid};
      default: return {if256.busy, if256.done, if256.key_valid};
    endcase
  endfunction

  function automatic logic [127:0] dut_rd(input int s);
    case (s)
      0:       return if128.rd_key;
      1:       return if192.rd_key;
      default: return if256.rd_key;
    endcase
  endfunction

  // S-box built by brute-force inverse search plus the FIPS-197 affine transform.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sb [256];

  initial begin : build_sbox
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  end

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  // Reference state: full schedule plus cycle-level busy/done/valid expectations.
  logic [31:0]  sched [3][60];
  bit           m_busy [3], m_done [3], m_valid [3], rd_ok [3];
  int           rem [3];
  logic [127:0] m_rd [3];
  bit           live = 1'b0;

  task automatic expand_model(input int s);
    int nk, tw;
    logic [31:0] temp;
    logic [7:0]  rc;
    nk = nk_of(s);
    tw = 4 * (nr_of(s) + 1);
    rc = 8'h01;
    for (int j = 0; j < nk; j++) sched[s][j] = key_v[s][32*j +: 32];
    for (int i = nk; i < tw; i++) begin
      temp = sched[s][i-1];
      if (i % nk == 0) begin
        temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        temp = subw(temp);
      end
      sched[s][i] = sched[s][i-nk] ^ temp;
    end
  endtask

  always @(posedge clk) begin : model
    for (int s = 0; s < 3; s++) begin
      int r;
      r = int'(rd_v[s]);
      rd_ok[s] = 1'b1;
      if (rst || r > nr_of(s)) m_rd[s] = '0;
      else if (m_valid[s])     m_rd[s] = {sched[s][4*r], sched[s][4*r+1], sched[s][4*r+2], sched[s][4*r+3]};
      else                     rd_ok[s] = 1'b0;
      if (rst) begin
        m_busy[s] = 1'b0; m_done[s] = 1'b0; m_valid[s] = 1'b0;
      end else begin
        m_done[s] = 1'b0;
        if (start_v[s] && !m_busy[s]) begin
          expand_model(s);
          rem[s]     = 4 * (nr_of(s) + 1) - nk_of(s);
          m_busy[s]  = 1'b1;
          m_valid[s] = 1'b0;
        end else if (m_busy[s]) begin
          rem[s]--;
          if (rem[s] == 0) begin
            m_busy[s] = 1'b0; m_valid[s] = 1'b1; m_done[s] = 1'b1;
          end
        end
      end
    end
    live = 1'b1;
  end

  always @(negedge clk) begin : compare
    if (live) begin
      for (int s = 0; s < 3; s++) begin
        logic [2:0] f;
        f = flags(s);
        check($sformatf("busy%0d", s),  128'(f[2]), 128'(m_busy[s]));
        check($sformatf("done%0d", s),  128'(f[1]), 128'(m_done[s]));
        check($sformatf("valid%0d", s), 128'(f[0]), 128'(m_valid[s]));
        if (rd_ok[s]) check($sformatf("rd_key%0d", s), dut_rd(s), m_rd[s]);
      end
    end
  end

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int s, input string name);
    bit   seen;
    logic [2:0] f;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      tick();
      f = flags(s);
      seen = f[1];
    end
    check(name, 128'(seen), 128'd1);
  endtask

  initial begin : stimulus
    int         lat [3];
    logic [2:0] f;
    for (int s = 0; s < 3; s++) begin
      start_v[s] = 1'b0; key_v[s] = '0; rd_v[s] = '0; lat[s] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags128", 128'(flags(0)), 128'd0);
    check("reset_rdkey128", dut_rd(0), 128'd0);
    rst = 1'b0;

    // Known-answer expansions on all three sizes; a second start mid-run on the 128-bit one.
    key_v[0] = {KEY1, 128'h0};
    key_v[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    key_v[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    for (int s = 0; s < 3; s++) start_v[s] = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) start_v[s] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 10) start_v[0] = 1'b1;
      if (k == 11) start_v[0] = 1'b0;
      tick();
      for (int s = 0; s < 3; s++) begin
        f = flags(s);
        if (lat[s] == 0 && f[1]) lat[s] = k;
      end
    end
    check("latency128", 128'(lat[0]), 128'd40);
    check("latency192", 128'(lat[1]), 128'd46);
    check("latency256", 128'(lat[2]), 128'd52);

    rd_v[0] = 4'd1; rd_v[1] = 4'd12; rd_v[2] = 4'd14;
    tick();
    check("k128_round1",  dut_rd(0), 128'ha0fafe1788542cb123a339392a6c7605);
    check("k192_round12", dut_rd(1), 128'he98ba06f448c773c8ecc720401002202);
    check("k256_round14", dut_rd(2), 128'hfe4890d1e6188d0b046df344706c631e);
    rd_v[0] = 4'd10;
    tick();
    check("k128_round10", dut_rd(0), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (20) begin
      for (int s = 0; s < 3; s++) rd_v[s] = 4'($urandom_range(0, 15));
      tick();
    end

    // Rekey with the all-zero key while the old schedule is valid.
    key_v[0] = '0; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    f = flags(0);
    check("rekey_valid_drop", 128'(f[0]), 128'd0);
    wait_done(0, "rekey_done_seen");
    rd_v[0] = 4'd10;
    tick();
    check("zero_round10", dut_rd(0), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Reset part-way through an expansion, then a clean run.
    key_v[0] = {KEY1, 128'h0}; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_flags", 128'(flags(0)), 128'd0);
    check("abort_rdkey", dut_rd(0), 128'd0);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    wait_done(0, "restart_done_seen");
    rd_v[0] = 4'd10;
    tick();
    check("restart_round10", dut_rd(0), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_v[0] = 4'd11;
    tick();
    check("rd_round_11_zero", dut_rd(0), 128'd0);

    // start held high: re-accept exactly one cycle after done.
    key_v[0] = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    start_v[0] = 1'b1;
    tick();
    key_v[0] = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    wait_done(0, "b2b_done_seen");
    tick();
    f = flags(0);
    check("b2b_reaccept_busy", 128'(f[2]), 128'd1);
    check("b2b_done_width",    128'(f[1]), 128'd0);
    wait_done(0, "b2b_second_done");
    start_v[0] = 1'b0;
    tick();

    // Random traffic on all three engines, occasional reset.
    repeat (400) begin
      for (int s = 0; s < 3; s++) begin
        key_v[s]   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start_v[s] = ($urandom_range(0, 31) == 0);
        rd_v[s]    = 4'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    for (int s = 0; s < 3; s++) start_v[s] = 1'b0;
    repeat (60) begin
      for (int s = 0; s < 3; s++) rd_v[s] = 4'($urandom_range(0, 15));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
